// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scanner.
package seg_pkg;
  localparam int NUM_DIGITS = 3;
  localparam int DP_BIT     = 0;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_0 = 8'hFC;
  localparam logic [7:0] SEG_1 = 8'h60;
  localparam logic [7:0] SEG_2 = 8'hDA;
  localparam logic [7:0] SEG_3 = 8'hF2;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'hB6;
  localparam logic [7:0] SEG_6 = 8'hBE;
  localparam logic [7:0] SEG_7 = 8'hE0;
  localparam logic [7:0] SEG_8 = 8'hFE;
  localparam logic [7:0] SEG_9 = 8'hE6;

  typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_t;
endpackage

// File: rtl/seg_scan_timer.sv
// Slot prescaler, digit index and BLANK/DRIVE window; flags the frame wrap.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic        clk,
  input  logic        rst,
  output logic [1:0]  digit,
  output scan_state_t state,
  output logic        wrap,
  output logic        frame_done
);
  localparam int PW = $clog2(SLOT_CYCLES);

  logic [PW-1:0] p;
  logic          slot_end;

  assign slot_end = (p == PW'(SLOT_CYCLES - 1));
  // wrap is the last cycle of the last digit; the edge that ends it is the frame boundary
  assign wrap     = slot_end && (digit == 2'(NUM_DIGITS - 1));
  assign state    = (p < PW'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;

  always_ff @(posedge clk) begin
    if (rst) begin
      p          <= '0;
      digit      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (slot_end) begin
        p     <= '0;
        digit <= wrap ? 2'd0 : digit + 2'd1;
      end else begin
        p <= p + PW'(1);
      end
    end
  end
endmodule

// File: rtl/seg_scan_mux.sv
// Three-digit scan multiplexer: frame-coherent shadows, blink gating, registered outputs.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 50,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg0,
  input  logic [7:0]            seg1,
  input  logic [7:0]            seg2,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  blink_en,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_done
);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [1:0]                 digit;
  scan_state_t                state;
  logic                       wrap;
  logic [NUM_DIGITS-1:0][7:0] shadow;
  logic [FW-1:0]              f;
  logic                       blink_phase;
  logic [7:0]                 cur_seg;
  logic                       cur_dp;
  logic                       lit;

  seg_scan_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .digit     (digit),
    .state     (state),
    .wrap      (wrap),
    .frame_done(frame_done)
  );

  // Capture on the frame edge so a whole frame shows one consistent value
  always_ff @(posedge clk) begin
    if (rst || wrap) shadow <= {seg2, seg1, seg0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f           <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (f == FW'(BLINK_FRAMES - 1)) begin
        f           <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        f <= f + FW'(1);
      end
    end
  end

  always_comb begin
    cur_seg = SEG_BLANK;
    cur_dp  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit == 2'(k)) begin
        cur_seg = shadow[k];
        cur_dp  = dp_mask[k];
      end
    end
  end

  assign lit = (state == ST_DRIVE) && !(blink_en && blink_phase);

  always_ff @(posedge clk) begin
    if (rst || !lit) begin
      seg_out <= SEG_BLANK;
      dig_en  <= '0;
    end else begin
      seg_out <= cur_seg | (8'(cur_dp) << DP_BIT);
      dig_en  <= NUM_DIGITS'(1) << digit;
    end
  end
endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboarded bench for seg_scan_mux with short slots (10 cycles, 2 blank, 2 blink frames).
module tb_seg_scan_mux;
  localparam int SC = 10, BC = 2, BF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] seg0 = 8'hFC, seg1 = 8'h60, seg2 = 8'hDA;
  logic [2:0] dp_mask = 3'b000;
  logic       blink_en = 1'b0;
  logic [7:0] seg_out;
  logic [2:0] dig_en;
  logic       frame_done;

  seg_scan_mux #(.SLOT_CYCLES(SC), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .seg0(seg0), .seg1(seg1), .seg2(seg2),
    .dp_mask(dp_mask), .blink_en(blink_en),
    .seg_out(seg_out), .dig_en(dig_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seg;
    logic [2:0] en;
    logic       fd;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] seg;
    logic [2:0] en;
    logic       fd;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   t = 0;
  bit   use_tbl = 0;
  exp_t sb[$];
  vec_t tbl[12];
  logic [7:0] exp_sh [3];

  task automatic check(input string name, input logic [7:0] s, input logic [2:0] e, input logic fd,
                       input logic [7:0] xs, input logic [2:0] xe, input logic xfd);
    checks++;
    if (s !== xs || e !== xe || fd !== xfd) begin
      errors++;
      $display("FAIL %s t=%0d: got seg=%h en=%b fd=%b, want seg=%h en=%b fd=%b",
               name, t, s, e, fd, xs, xe, xfd);
    end
  endtask

  // Expected outputs for cycle t of the current run, from slot/frame arithmetic
  function automatic exp_t model(input int tc);
    exp_t x;
    int   p = tc % SC;
    int   d = (tc / SC) % 3;
    bit   dark_phase = ((tc / (3 * SC)) / BF) % 2 == 1;
    bit   lit = (p >= BC) && !(blink_en && dark_phase);
    x.seg = lit ? (exp_sh[d] | {7'b0, dp_mask[d]}) : 8'h00;
    x.en  = lit ? 3'(1 << d) : 3'b000;
    x.fd  = (tc % (3 * SC)) == (3 * SC - 1);
    return x;
  endfunction

  task automatic run(input int n);
    exp_t x, got;
    for (int i = 0; i < n; i++) begin
      sb.push_back(model(t));
      @(posedge clk);
      if (t % (3 * SC) == 3 * SC - 1) begin
        exp_sh[0] = seg0; exp_sh[1] = seg1; exp_sh[2] = seg2;
      end
      #1;
      x = sb.pop_front();
      check("scan", seg_out, dig_en, frame_done, x.seg, x.en, x.fd);
      if (use_tbl)
        foreach (tbl[k])
          if (tbl[k].cyc == t)
            check("tbl", seg_out, dig_en, frame_done, tbl[k].seg, tbl[k].en, tbl[k].fd);
      t++;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("reset", seg_out, dig_en, frame_done, 8'h00, 3'b000, 1'b0);
    end
    rst = 1'b0;
    exp_sh[0] = seg0; exp_sh[1] = seg1; exp_sh[2] = seg2;
    t = 0;
  endtask

  // Structural invariants on every cycle outside reset
  logic [2:0] last_en = 3'b000;
  int         dark_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      last_en  = 3'b000;
      dark_run = 0;
    end else begin
      checks++;
      if ((dig_en & (dig_en - 3'd1)) != 3'b000 || (dig_en == 3'b000 && seg_out != 8'h00)) begin
        errors++;
        $display("FAIL invariant: got en=%b seg=%h, want onehot0 en and dark seg", dig_en, seg_out);
      end
      if (dig_en != 3'b000) begin
        if (last_en != 3'b000 && dig_en != last_en && dark_run < BC) begin
          errors++;
          $display("FAIL gap: got %0d dark cycles, want >= %0d", dark_run, BC);
        end
        last_en  = dig_en;
        dark_run = 0;
      end else begin
        dark_run++;
      end
    end
  end

  initial begin
    tbl[0]  = '{0,  8'h00, 3'b000, 1'b0};
    tbl[1]  = '{1,  8'h00, 3'b000, 1'b0};
    tbl[2]  = '{2,  8'hFC, 3'b001, 1'b0};
    tbl[3]  = '{9,  8'hFC, 3'b001, 1'b0};
    tbl[4]  = '{10, 8'h00, 3'b000, 1'b0};
    tbl[5]  = '{12, 8'h60, 3'b010, 1'b0};
    tbl[6]  = '{19, 8'h60, 3'b010, 1'b0};
    tbl[7]  = '{22, 8'hDA, 3'b100, 1'b0};
    tbl[8]  = '{28, 8'hDA, 3'b100, 1'b0};
    tbl[9]  = '{29, 8'hDA, 3'b100, 1'b1};
    tbl[10] = '{30, 8'h00, 3'b000, 1'b0};
    tbl[11] = '{59, 8'hDA, 3'b100, 1'b1};

    // basic scan against the fixed table
    do_reset(3);
    use_tbl = 1;
    run(60);
    use_tbl = 0;

    // mid-frame changes wait for the next capture
    do_reset(2);
    run(16);
    seg0 = 8'h60; seg1 = 8'hF2;
    run(1);
    check("tear_old", seg_out, dig_en, frame_done, 8'h60, 3'b010, 1'b0);
    run(33);
    check("tear_new", seg_out, dig_en, frame_done, 8'hF2, 3'b010, 1'b0);

    // live dp on digit 2
    seg0 = 8'hFC; seg1 = 8'h60; seg2 = 8'hDA;
    do_reset(2);
    dp_mask = 3'b100;
    run(23);
    check("dp", seg_out, dig_en, frame_done, 8'hDB, 3'b100, 1'b0);
    run(7);
    dp_mask = 3'b000;

    // blink: frames 2-3 dark, frame_done unaffected
    do_reset(2);
    blink_en = 1'b1;
    run(150);
    blink_en = 1'b0;

    // reset asserted mid-slot, then scanning restarts cleanly
    do_reset(2);
    run(15);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst", seg_out, dig_en, frame_done, 8'h00, 3'b000, 1'b0);
    do_reset(1);
    use_tbl = 1;
    run(60);
    use_tbl = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
